sequence_checker: RTL
=====================

SEQUENCE_CHECKER -- requirements
Module: sequence_checker

Interface
REQ-001 Parameter ERR_W, default 8: width of error_count.
REQ-002 Parameter FRM_W, default 16: width of frame_count.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 data_in  input  8  received byte.
REQ-006 data_valid  input  1  data_in is valid this cycle.
REQ-007 locked  output  1  checker is aligned to the sequence.
REQ-008 expected_idx  output  3  index (0-7) of the next expected byte.
REQ-009 seq_done  output  1  one-cycle pulse: an 8-byte sequence completed correctly.
REQ-010 error  output  1  one-cycle pulse: mismatch while locked.
REQ-011 error_count  output  ERR_W  saturating count of locked-state mismatches.
REQ-012 frame_count  output  FRM_W  wrapping count of completed sequences.

Function
REQ-013 The expected sequence SHALL be, for idx 0-7: AF, BC, E2, 78, FF, E2, 0B, 8D (hex), held in an internal constant table.
REQ-014 The FSM SHALL have three states: HUNT, VERIFY and LOCKED.
REQ-015 All outputs SHALL be registered, and SHALL reflect a valid byte in the cycle after it is sampled.
REQ-016 When data_valid is 0, the state, idx and counters SHALL hold, and seq_done and error SHALL be 0.
REQ-017 In HUNT, a valid byte of AF SHALL cause a move to VERIFY with idx=1; any other valid byte SHALL leave the block in HUNT with idx=0.
REQ-018 In VERIFY, a valid byte equal to table[idx] SHALL advance idx by 1.
REQ-019 In VERIFY, when idx=7 and the byte matches, the block SHALL move to LOCKED with idx=0, pulse seq_done and increment frame_count.
REQ-020 In VERIFY, a mismatching byte of AF SHALL restart VERIFY at idx=1; any other mismatching byte SHALL return the block to HUNT with idx=0. No error pulse is raised in VERIFY.
REQ-021 In LOCKED, a matching valid byte SHALL advance idx modulo 8.
REQ-022 In LOCKED, a match at idx=7 SHALL pulse seq_done, increment frame_count and wrap idx to 0.
REQ-023 In LOCKED, a mismatch SHALL pulse error and increment error_count.
REQ-024 After a LOCKED mismatch, the next state SHALL be VERIFY with idx=1 if the byte is AF, otherwise HUNT with idx=0.
REQ-025 locked SHALL be 1 exactly when the state is LOCKED.
REQ-026 error_count SHALL saturate at 2^ERR_W-1 and never wrap.
REQ-027 frame_count SHALL wrap from 2^FRM_W-1 to 0.
REQ-028 The repeated value E2 (idx 2 and 5) SHALL be checked positionally only; an E2 never re-aligns idx.
REQ-029 seq_done and error SHALL never be asserted in the same cycle.

Reset
REQ-030 While rst_n=0, the block SHALL immediately be in HUNT with idx=0, locked=0, seq_done=0, error=0, error_count=0 and frame_count=0.
REQ-031 Reset SHALL abort any partial VERIFY or LOCKED progress.
REQ-032 The first valid byte is sampled on the first rising edge after rst_n deasserts.

Verification
REQ-033 Reset, then one full sequence AF..8D with valid=1 each cycle -> locked=1 and seq_done=1 in the cycle after 8D; frame_count=1; error=0 throughout.
REQ-034 Three back-to-back sequences, with valid=0 gaps inserted randomly -> frame_count=3; locked stays 1; gaps do not change idx.
REQ-035 Locked, then idx 3 receives 00 instead of 78 -> error pulses, error_count=1, next state HUNT; a full resync sequence relocks with frame_count incremented.
REQ-036 Locked, then AF arrives at idx 4 -> error pulses, state VERIFY with idx=1; BC E2 78 FF E2 0B 8D then relocks.
REQ-037 In HUNT, feed AF BC E2 AF BC E2 78 FF E2 0B 8D -> VERIFY restarts on the second AF; lock occurs only after the final 8D; no error pulse.
REQ-038 Force error_count to 2^ERR_W-1 with repeated mismatches -> it holds at all-ones; rst_n pulsed mid-sequence -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/sequence_checker.sv
// Aligns to the fixed 8-byte pattern AF BC E2 78 FF E2 0B 8D. It reports each
// completed pattern and counts mismatches seen while aligned.
module sequence_checker #(
  parameter int unsigned ERR_W = 8,
  parameter int unsigned FRM_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  output logic             locked,
  output logic [2:0]       expected_idx,
  output logic             seq_done,
  output logic             error,
  output logic [ERR_W-1:0] error_count,
  output logic [FRM_W-1:0] frame_count
);

  typedef enum logic [1:0] {StHunt, StVerify, StLocked} state_e;

  localparam logic [7:0]       SyncByte = 8'hAF;
  localparam logic [ERR_W-1:0] ErrMax   = '1;

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic             locked_q, locked_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [FRM_W-1:0] frm_cnt_q, frm_cnt_d;
  logic [7:0]       exp_byte;
  logic             match;

  always_comb begin
    unique case (idx_q)
      3'd0: exp_byte = 8'hAF;
      3'd1: exp_byte = 8'hBC;
      3'd2: exp_byte = 8'hE2;
      3'd3: exp_byte = 8'h78;
      3'd4: exp_byte = 8'hFF;
      3'd5: exp_byte = 8'hE2;
      3'd6: exp_byte = 8'h0B;
      3'd7: exp_byte = 8'h8D;
    endcase
  end

  assign match = (data_in == exp_byte);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    frm_cnt_d = frm_cnt_q;
    if (data_valid) begin
      unique case (state_q)
        StHunt: begin
          if (data_in == SyncByte) begin
            state_d = StVerify;
            idx_d   = 3'd1;
          end else begin
            idx_d   = 3'd0;
          end
        end
        StVerify, StLocked: begin
          if (match) begin
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_d   = StLocked;
              done_d    = 1'b1;
              frm_cnt_d = frm_cnt_q + FRM_W'(1);
            end
          end else begin
            if (state_q == StLocked) begin
              err_d = 1'b1;
              if (err_cnt_q != ErrMax) err_cnt_d = err_cnt_q + ERR_W'(1);
            end
            // Realignment is only ever triggered by the sync byte, never by a repeated E2
            if (data_in == SyncByte) begin
              state_d = StVerify;
              idx_d   = 3'd1;
            end else begin
              state_d = StHunt;
              idx_d   = 3'd0;
            end
          end
        end
        default: begin
          state_d = StHunt;
          idx_d   = 3'd0;
        end
      endcase
    end
    locked_d = (state_d == StLocked);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StHunt;
      idx_q     <= 3'd0;
      locked_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      frm_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      locked_q  <= locked_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      frm_cnt_q <= frm_cnt_d;
    end
  end

  assign locked       = locked_q;
  assign expected_idx = idx_q;
  assign seq_done     = done_q;
  assign error        = err_q;
  assign error_count  = err_cnt_q;
  assign frame_count  = frm_cnt_q;

endmodule
